// File: rtl/bitonic_sorter_pipelined_if.sv
// Handshake and data bundle for bitonic_sorter_pipelined.
// post_sort_index_out exists only when BITONIC_SORTER_INDEX_OUT_EN is defined.
interface bitonic_sorter_pipelined_if #(
    parameter int SINGLE_WAY_WIDTH_IN_BITS = 32,
    parameter int NUM_WAY                  = 16,
    parameter int LOG_NUM_WAY              = 4
);
    logic                                         in_valid;
    logic                                         in_ready;
    logic                                         in_descend;
    logic [SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY-1:0]  pre_sort_flatted_in;
    logic                                         out_valid;
    logic                                         out_ready;
    logic                                         out_descend;
    logic [SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY-1:0]  post_sort_flatted_out;

    if ((2 ** LOG_NUM_WAY) != NUM_WAY || NUM_WAY < 2) begin : g_bad_param
        $error("bitonic_sorter_pipelined_if: NUM_WAY must equal 2**LOG_NUM_WAY and be at least 2");
    end

`ifdef BITONIC_SORTER_INDEX_OUT_EN
    logic [LOG_NUM_WAY*NUM_WAY-1:0]               post_sort_index_out;

    modport master (
        output in_valid, in_descend, pre_sort_flatted_in, out_ready,
        input  in_ready, out_valid, out_descend, post_sort_flatted_out, post_sort_index_out
    );
    modport slave (
        input  in_valid, in_descend, pre_sort_flatted_in, out_ready,
        output in_ready, out_valid, out_descend, post_sort_flatted_out, post_sort_index_out
    );
`else
    modport master (
        output in_valid, in_descend, pre_sort_flatted_in, out_ready,
        input  in_ready, out_valid, out_descend, post_sort_flatted_out
    );
    modport slave (
        input  in_valid, in_descend, pre_sort_flatted_in, out_ready,
        output in_ready, out_valid, out_descend, post_sort_flatted_out
    );
`endif
endinterface

// File: rtl/bitonic_sorter_pipelined.sv
// Fully pipelined N-way bitonic sorter: one compare-exchange layer per register slot.
// Optional macro BITONIC_SORTER_INDEX_OUT_EN carries each key's original way index.
module bitonic_sorter_pipelined #(
    parameter int SINGLE_WAY_WIDTH_IN_BITS = 32,
    parameter int NUM_WAY                  = 16,
    parameter int LOG_NUM_WAY              = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    bitonic_sorter_pipelined_if.slave io
);
    localparam int W         = SINGLE_WAY_WIDTH_IN_BITS;
    localparam int N         = NUM_WAY;
    localparam int L         = LOG_NUM_WAY;
    localparam int NUM_STAGE = (L * (L + 1)) / 2;
    localparam int LAST      = NUM_STAGE - 1;

    typedef logic [N-1:0][W-1:0] keys_t;

    if ((2 ** L) != N || N < 2) begin : g_bad_param
        $error("bitonic_sorter_pipelined: NUM_WAY must equal 2**LOG_NUM_WAY and be at least 2");
    end

    logic                 advance;
    logic [NUM_STAGE-1:0] valid_d;
    logic [NUM_STAGE-1:0] valid_q;
    logic [NUM_STAGE-1:0] desc_d;
    logic [NUM_STAGE-1:0] desc_q;
    keys_t                src_key [NUM_STAGE];
    keys_t                net_key [NUM_STAGE];
    keys_t                key_d   [NUM_STAGE];
    keys_t                key_q   [NUM_STAGE];

`ifdef BITONIC_SORTER_INDEX_OUT_EN
    typedef logic [N-1:0][L-1:0] idx_t;
    idx_t                 src_idx [NUM_STAGE];
    idx_t                 net_idx [NUM_STAGE];
    idx_t                 idx_d   [NUM_STAGE];
    idx_t                 idx_q   [NUM_STAGE];
`endif

    // The whole pipe moves in lockstep; only a stalled valid output blocks it.
    assign advance = !valid_q[LAST] || io.out_ready;

    // Each layer consumes the previous slot; layer 0 consumes the input port.
    always_comb begin
        src_key    = key_q;
        valid_d    = '0;
        desc_d     = '0;
        src_key[0] = io.pre_sort_flatted_in;
        valid_d[0] = io.in_valid;
        desc_d[0]  = io.in_descend;
        for (int s = 1; s < NUM_STAGE; s++) begin
            src_key[s] = key_q[s-1];
            valid_d[s] = valid_q[s-1];
            desc_d[s]  = desc_q[s-1];
        end
`ifdef BITONIC_SORTER_INDEX_OUT_EN
        src_idx = idx_q;
        for (int i = 0; i < N; i++) begin
            src_idx[0][i] = L'(i);
        end
        for (int s = 1; s < NUM_STAGE; s++) begin
            src_idx[s] = idx_q[s-1];
        end
`endif
    end

    // Layer (k,j) pairs way lo with lo|(1<<j); bit k of lo picks the direction.
    always_comb begin
        int   s;
        int   lo;
        int   hi;
        logic swap;
        net_key = src_key;
`ifdef BITONIC_SORTER_INDEX_OUT_EN
        net_idx = src_idx;
`endif
        s    = 0;
        lo   = 0;
        hi   = 0;
        swap = 1'b0;
        for (int k = 1; k <= L; k++) begin
            for (int j = k - 1; j >= 0; j--) begin
                s = ((k * (k - 1)) / 2) + (k - 1 - j);
                for (int m = 0; m < N / 2; m++) begin
                    lo = ((m >> j) << (j + 1)) | (m & ((1 << j) - 1));
                    hi = lo | (1 << j);
                    // Strict compares: equal keys never swap.
                    if (((lo >> k) & 1) == 0) begin
                        swap = src_key[s][lo] > src_key[s][hi];
                    end else begin
                        swap = src_key[s][lo] < src_key[s][hi];
                    end
                    net_key[s][lo] = swap ? src_key[s][hi] : src_key[s][lo];
                    net_key[s][hi] = swap ? src_key[s][lo] : src_key[s][hi];
`ifdef BITONIC_SORTER_INDEX_OUT_EN
                    net_idx[s][lo] = swap ? src_idx[s][hi] : src_idx[s][lo];
                    net_idx[s][hi] = swap ? src_idx[s][lo] : src_idx[s][hi];
`endif
                end
            end
        end
    end

    // The network always sorts ascending; descending mode mirrors the last layer.
    always_comb begin
        key_d = net_key;
`ifdef BITONIC_SORTER_INDEX_OUT_EN
        idx_d = net_idx;
`endif
        if (desc_d[LAST]) begin
            for (int i = 0; i < N; i++) begin
                key_d[LAST][i] = net_key[LAST][N-1-i];
`ifdef BITONIC_SORTER_INDEX_OUT_EN
                idx_d[LAST][i] = net_idx[LAST][N-1-i];
`endif
            end
        end else begin
            key_d[LAST] = net_key[LAST];
`ifdef BITONIC_SORTER_INDEX_OUT_EN
            idx_d[LAST] = net_idx[LAST];
`endif
        end
    end

    // Slot control bits: reset drops every in-flight vector.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            desc_q  <= '0;
        end else if (advance) begin
            valid_q <= valid_d;
            desc_q  <= desc_d;
        end else begin
            valid_q <= valid_q;
            desc_q  <= desc_q;
        end
    end

`ifdef BITONIC_SORTER_INDEX_OUT_EN
    // Slot key and index payload, cleared on reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            key_q <= '{default: '0};
            idx_q <= '{default: '0};
        end else if (advance) begin
            key_q <= key_d;
            idx_q <= idx_d;
        end else begin
            key_q <= key_q;
            idx_q <= idx_q;
        end
    end

    assign io.post_sort_index_out = idx_q[LAST];
`else
    // Slot key payload; bubbles register don't-care data, so no reset is needed.
    always_ff @(posedge clock) begin
        if (advance) begin
            key_q <= key_d;
        end else begin
            key_q <= key_q;
        end
    end
`endif

    assign io.in_ready              = advance;
    assign io.out_valid             = valid_q[LAST];
    assign io.out_descend           = desc_q[LAST];
    assign io.post_sort_flatted_out = key_q[LAST];

endmodule

// File: tb/tb_bitonic_sorter_pipelined.sv
// Directed bench for bitonic_sorter_pipelined: a 16x32 instance and a 4x8 instance.
module tb_bitonic_sorter_pipelined;
    localparam int W   = 32;
    localparam int N   = 16;
    localparam int L   = 4;
    localparam int NS  = 10;
    localparam int W4  = 8;
    localparam int N4  = 4;
    localparam int L4  = 2;
    localparam int NS4 = 3;

    typedef logic [W*N-1:0] vec_t;

    logic clock = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clock = ~clock;

    bitonic_sorter_pipelined_if #(.SINGLE_WAY_WIDTH_IN_BITS(W),  .NUM_WAY(N),  .LOG_NUM_WAY(L))  io16 ();
    bitonic_sorter_pipelined_if #(.SINGLE_WAY_WIDTH_IN_BITS(W4), .NUM_WAY(N4), .LOG_NUM_WAY(L4)) io4 ();

    bitonic_sorter_pipelined #(.SINGLE_WAY_WIDTH_IN_BITS(W), .NUM_WAY(N), .LOG_NUM_WAY(L)) u_dut (
        .clock (clock),
        .reset (reset),
        .io    (io16)
    );

    bitonic_sorter_pipelined #(.SINGLE_WAY_WIDTH_IN_BITS(W4), .NUM_WAY(N4), .LOG_NUM_WAY(L4)) u_dut4 (
        .clock (clock),
        .reset (reset),
        .io    (io4)
    );

    function automatic vec_t make_vec(input int v);
        vec_t         r;
        logic [W-1:0] x;
        r = '0;
        for (int w = 0; w < N; w++) begin
            x = 32'h9E37_79B1 * 32'(v + 1) + 32'h7F4A_7C15 * 32'(w);
            x = x ^ (x >> 13);
            if (w % 5 == 3) x = 32'h0000_1000 + 32'(v);
            r[w*W +: W] = x;
        end
        return r;
    endfunction

    function automatic vec_t ref_sort(input vec_t v, input logic desc);
        logic [W-1:0] a [N];
        logic [W-1:0] t;
        vec_t         r;
        for (int i = 0; i < N; i++) a[i] = v[i*W +: W];
        for (int i = 1; i < N; i++) begin
            for (int j = i; j > 0; j--) begin
                if (a[j-1] > a[j]) begin
                    t      = a[j];
                    a[j]   = a[j-1];
                    a[j-1] = t;
                end
            end
        end
        r = '0;
        for (int i = 0; i < N; i++) r[i*W +: W] = desc ? a[N-1-i] : a[i];
        return r;
    endfunction

    task automatic idle_all();
        io16.in_valid            = 1'b0;
        io16.in_descend          = 1'b0;
        io16.pre_sort_flatted_in = '0;
        io16.out_ready           = 1'b1;
        io4.in_valid             = 1'b0;
        io4.in_descend           = 1'b0;
        io4.pre_sort_flatted_in  = '0;
        io4.out_ready            = 1'b1;
    endtask

    task automatic drive16(input vec_t v, input logic d);
        io16.in_valid            = 1'b1;
        io16.in_descend          = d;
        io16.pre_sort_flatted_in = v;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_all();
        repeat (2) @(negedge clock);
        total++; if (io16.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", io16.out_valid); end
        total++; if (io16.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", io16.in_ready); end
        total++; if (io16.out_descend !== 1'b0) begin bad++; $display("FAIL reset_out_descend: got %b want 0", io16.out_descend); end
        total++; if (io4.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid4: got %b want 0", io4.out_valid); end
        total++; if (io4.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready4: got %b want 1", io4.in_ready); end
        reset = 1'b0;
        @(negedge clock);
        total++; if (io16.out_valid !== 1'b0) begin bad++; $display("FAIL post_reset_valid: got %b want 0", io16.out_valid); end
    endtask

    task automatic test_small_sort(input logic desc, input logic [31:0] exp_keys, input logic [7:0] exp_idx);
        @(negedge clock);
        io4.in_valid            = 1'b1;
        io4.in_descend          = desc;
        io4.pre_sort_flatted_in = 32'h0107_0309;
        @(negedge clock);
        io4.in_valid            = 1'b0;
        io4.in_descend          = ~desc;
        io4.pre_sort_flatted_in = '0;
        for (int c = 1; c < NS4; c++) begin
            total++; if (io4.out_valid !== 1'b0) begin bad++; $display("FAIL small_early_valid c=%0d: got %b want 0", c, io4.out_valid); end
            @(negedge clock);
        end
        total++; if (io4.out_valid !== 1'b1) begin bad++; $display("FAIL small_valid: got %b want 1", io4.out_valid); end
        total++; if (io4.post_sort_flatted_out !== exp_keys) begin bad++; $display("FAIL small_keys: got %h want %h", io4.post_sort_flatted_out, exp_keys); end
        total++; if (io4.out_descend !== desc) begin bad++; $display("FAIL small_descend: got %b want %b", io4.out_descend, desc); end
`ifdef BITONIC_SORTER_INDEX_OUT_EN
        total++; if (io4.post_sort_index_out !== exp_idx) begin bad++; $display("FAIL small_index: got %h want %h", io4.post_sort_index_out, exp_idx); end
`else
        if (exp_idx === 8'hxx) $display("note: index check unavailable");
`endif
        @(negedge clock);
        total++; if (io4.out_valid !== 1'b0) begin bad++; $display("FAIL small_after_valid: got %b want 0", io4.out_valid); end
    endtask

    task automatic test_back_to_back();
        vec_t exp_v [16];
        int   k;
        logic e_desc;
        for (int v = 0; v < 16; v++) exp_v[v] = ref_sort(make_vec(v), (v % 2) == 1);
        @(negedge clock);
        drive16(make_vec(0), 1'b0);
        for (int n = 1; n <= NS + 16; n++) begin
            @(negedge clock);
            k = n - NS;
            if (k >= 0 && k < 16) begin
                e_desc = (k % 2) == 1;
                total++; if (io16.out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid[%0d]: got %b want 1", k, io16.out_valid); end
                total++; if (io16.post_sort_flatted_out !== exp_v[k]) begin bad++; $display("FAIL b2b_data[%0d]: got %h want %h", k, io16.post_sort_flatted_out, exp_v[k]); end
                total++; if (io16.out_descend !== e_desc) begin bad++; $display("FAIL b2b_descend[%0d]: got %b want %b", k, io16.out_descend, e_desc); end
            end else begin
                total++; if (io16.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle_valid n=%0d: got %b want 0", n, io16.out_valid); end
            end
            total++; if (io16.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready n=%0d: got %b want 1", n, io16.in_ready); end
            if (n < 16) drive16(make_vec(n), (n % 2) == 1);
            else io16.in_valid = 1'b0;
        end
    endtask

    task automatic test_stall();
        vec_t e0, e1, e2;
        e0 = ref_sort(make_vec(20), 1'b0);
        e1 = ref_sort(make_vec(21), 1'b1);
        e2 = ref_sort(make_vec(22), 1'b0);
        @(negedge clock); drive16(make_vec(20), 1'b0);
        @(negedge clock); drive16(make_vec(21), 1'b1);
        @(negedge clock); drive16(make_vec(22), 1'b0);
        @(negedge clock); io16.in_valid = 1'b0;
        repeat (NS - 3) @(negedge clock);
        total++; if (io16.post_sort_flatted_out !== e0 || io16.out_valid !== 1'b1) begin bad++; $display("FAIL stall_first: got %b/%h want 1/%h", io16.out_valid, io16.post_sort_flatted_out, e0); end
        io16.out_ready = 1'b0;
        #1;
        total++; if (io16.in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready_comb: got %b want 0", io16.in_ready); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            total++; if (io16.out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid c=%0d: got %b want 1", c, io16.out_valid); end
            total++; if (io16.post_sort_flatted_out !== e0) begin bad++; $display("FAIL stall_hold c=%0d: got %h want %h", c, io16.post_sort_flatted_out, e0); end
            total++; if (io16.out_descend !== 1'b0) begin bad++; $display("FAIL stall_descend c=%0d: got %b want 0", c, io16.out_descend); end
            total++; if (io16.in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready c=%0d: got %b want 0", c, io16.in_ready); end
        end
        io16.out_ready = 1'b1;
        @(negedge clock);
        total++; if (io16.out_valid !== 1'b1 || io16.post_sort_flatted_out !== e1 || io16.out_descend !== 1'b1) begin bad++; $display("FAIL stall_second: got %b/%b/%h want 1/1/%h", io16.out_valid, io16.out_descend, io16.post_sort_flatted_out, e1); end
        @(negedge clock);
        total++; if (io16.out_valid !== 1'b1 || io16.post_sort_flatted_out !== e2 || io16.out_descend !== 1'b0) begin bad++; $display("FAIL stall_third: got %b/%b/%h want 1/0/%h", io16.out_valid, io16.out_descend, io16.post_sort_flatted_out, e2); end
        @(negedge clock);
        total++; if (io16.out_valid !== 1'b0) begin bad++; $display("FAIL stall_drained: got %b want 0", io16.out_valid); end
    endtask

    task automatic test_equal_keys();
        vec_t v, e;
        v = '1;
        v[15*W +: W] = '0;
        e = '1;
        e[0 +: W] = '0;
        @(negedge clock); drive16(v, 1'b0);
        @(negedge clock); io16.in_valid = 1'b0;
        repeat (NS - 1) @(negedge clock);
        total++; if (io16.out_valid !== 1'b1) begin bad++; $display("FAIL equal_valid: got %b want 1", io16.out_valid); end
        total++; if (io16.post_sort_flatted_out !== e) begin bad++; $display("FAIL equal_keys: got %h want %h", io16.post_sort_flatted_out, e); end
        total++; if (io16.out_descend !== 1'b0) begin bad++; $display("FAIL equal_descend: got %b want 0", io16.out_descend); end
`ifdef BITONIC_SORTER_INDEX_OUT_EN
        total++; if (io16.post_sort_index_out[0 +: L] !== 4'd15) begin bad++; $display("FAIL equal_index0: got %0d want 15", io16.post_sort_index_out[0 +: L]); end
        for (int w = 0; w < N; w++) begin
            total++;
            if (v[int'(io16.post_sort_index_out[w*L +: L])*W +: W] !== io16.post_sort_flatted_out[w*W +: W]) begin
                bad++; $display("FAIL equal_index_key[%0d]: got idx %0d want idx of key %h", w, io16.post_sort_index_out[w*L +: L], io16.post_sort_flatted_out[w*W +: W]);
            end
        end
`endif
        @(negedge clock);
        total++; if (io16.out_valid !== 1'b0) begin bad++; $display("FAIL equal_after_valid: got %b want 0", io16.out_valid); end
    endtask

    task automatic test_reset_flush();
        vec_t e;
        e = ref_sort(make_vec(34), 1'b1);
        for (int v = 0; v < 4; v++) begin
            @(negedge clock); drive16(make_vec(30 + v), 1'b0);
        end
        @(negedge clock);
        io16.in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c <= NS; c++) begin
            total++; if (io16.out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid c=%0d: got %b want 0", c, io16.out_valid); end
            @(negedge clock);
        end
        drive16(make_vec(34), 1'b1);
        @(negedge clock); io16.in_valid = 1'b0;
        repeat (NS - 1) @(negedge clock);
        total++; if (io16.out_valid !== 1'b1) begin bad++; $display("FAIL flush_next_valid: got %b want 1", io16.out_valid); end
        total++; if (io16.post_sort_flatted_out !== e) begin bad++; $display("FAIL flush_next_data: got %h want %h", io16.post_sort_flatted_out, e); end
        total++; if (io16.out_descend !== 1'b1) begin bad++; $display("FAIL flush_next_descend: got %b want 1", io16.out_descend); end
    endtask

    initial begin
        test_reset();
        test_small_sort(1'b0, 32'h0907_0301, 8'h27);
        test_small_sort(1'b1, 32'h0103_0709, 8'hD8);
        test_back_to_back();
        test_stall();
        test_equal_keys();
        test_reset_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
